// File: rtl/alu_mul_seq_if.sv
// Signal bundle for alu_mul_seq: multiply request/response plus the shared-ALU
// arbitration bus (datapath side ext_*, ALU side alu_*).
interface alu_mul_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] ext_A;
  logic [WIDTH-1:0] ext_B;
  logic [2:0]       ext_op;
  logic [WIDTH-1:0] alu_A;
  logic [WIDTH-1:0] alu_B;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_R;

  // Environment side: requester, datapath and the shared ALU's result.
  modport master (
    output start, a, b, ext_A, ext_B, ext_op, alu_R,
    input  busy, done, product, alu_A, alu_B, alu_op
  );

  // Sequencer side.
  modport slave (
    input  start, a, b, ext_A, ext_B, ext_op, alu_R,
    output busy, done, product, alu_A, alu_B, alu_op
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier that borrows the core's shared ALU: passes datapath
// requests through while idle, otherwise drives ADD/SHIFT ops itself.
module alu_mul_seq #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_mul_seq_if.slave bus
);

  localparam int               IT_W     = $clog2(WIDTH) + 1;
  localparam logic [IT_W-1:0]  IT_MAX   = IT_W'(WIDTH);
  localparam logic [2:0]       OP_ADD   = 3'd2;
  localparam logic [2:0]       OP_SHIFT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TEST,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [IT_W-1:0]  it_q, it_d;
  logic [WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic             busy;
  logic             done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      it_q      <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      m_q       <= m_d;
      q_q       <= q_d;
      it_q      <= it_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    m_d       = m_q;
    q_d       = q_q;
    it_d      = it_q;
    product_d = product_q;
    alu_a     = bus.ext_A;
    alu_b     = bus.ext_B;
    alu_op    = bus.ext_op;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          p_d     = '0;
          m_d     = bus.a;
          q_d     = bus.b;
          it_d    = '0;
          state_d = S_TEST;
        end
      end
      S_TEST: begin
        busy   = 1'b1;
        alu_a  = '0;
        alu_b  = '0;
        alu_op = 3'd0;
        // Latch the result on the way into DONE so it is already visible there.
        if ((EARLY_EXIT && (q_q == '0)) || (it_q == IT_MAX)) begin
          product_d = p_q;
          state_d   = S_DONE;
        end else if (q_q[0]) begin
          state_d = S_ADD;
        end else begin
          state_d = S_SHL;
        end
      end
      S_ADD: begin
        busy    = 1'b1;
        alu_a   = p_q;
        alu_b   = m_q;
        alu_op  = OP_ADD;
        p_d     = bus.alu_R;
        state_d = S_SHL;
      end
      S_SHL: begin
        busy    = 1'b1;
        alu_a   = m_q;
        alu_b   = WIDTH'(1);
        alu_op  = OP_SHIFT;
        m_d     = bus.alu_R;
        state_d = S_SHR;
      end
      S_SHR: begin
        // A shift amount of -1 asks the ALU for a logical right shift by one.
        busy    = 1'b1;
        alu_a   = q_q;
        alu_b   = '1;
        alu_op  = OP_SHIFT;
        q_d     = bus.alu_R;
        it_d    = it_q + IT_W'(1);
        state_d = S_TEST;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.alu_A   = alu_a;
  assign bus.alu_B   = alu_b;
  assign bus.alu_op  = alu_op;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized self-checking bench for alu_mul_seq: an early-exit and a
// full-length instance share stimulus and are checked against arithmetic models.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [15:0] x_A = '0;
  logic [15:0] x_B = '0;
  logic [2:0]  x_op = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mul_seq_if #(.WIDTH(16)) bus_e ();
  alu_mul_seq_if #(.WIDTH(16)) bus_f ();

  alu_mul_seq #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_dut_e (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_e.slave)
  );

  alu_mul_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_dut_f (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_f.slave)
  );

  // Combinational shared-ALU model following the opcode contract.
  function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [15:0] x,
                                            input logic [15:0] y);
    logic [15:0] neg_y;
    neg_y = 16'(-y);
    case (op)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return 16'(x + y);
      3'd3:    return 16'(x - y);
      3'd4:    return ($signed(y) >= 0) ? 16'(x << y) : 16'(x >> neg_y);
      3'd5:    return {15'b0, ($signed(x) < $signed(y))};
      default: return 16'h0000;
    endcase
  endfunction

  assign bus_e.start  = st;
  assign bus_e.a      = op_a;
  assign bus_e.b      = op_b;
  assign bus_e.ext_A  = x_A;
  assign bus_e.ext_B  = x_B;
  assign bus_e.ext_op = x_op;
  assign bus_e.alu_R  = alu_model(bus_e.alu_op, bus_e.alu_A, bus_e.alu_B);
  assign bus_f.start  = st;
  assign bus_f.a      = op_a;
  assign bus_f.b      = op_b;
  assign bus_f.ext_A  = x_A;
  assign bus_f.ext_B  = x_B;
  assign bus_f.ext_op = x_op;
  assign bus_f.alu_R  = alu_model(bus_f.alu_op, bus_f.alu_A, bus_f.alu_B);

  logic        busy_w [2];
  logic        done_w [2];
  logic [15:0] prod_w [2];
  logic [15:0] aluA_w [2];
  logic [15:0] aluB_w [2];
  logic [2:0]  aluop_w[2];

  assign busy_w[0]  = bus_e.busy;
  assign busy_w[1]  = bus_f.busy;
  assign done_w[0]  = bus_e.done;
  assign done_w[1]  = bus_f.done;
  assign prod_w[0]  = bus_e.product;
  assign prod_w[1]  = bus_f.product;
  assign aluA_w[0]  = bus_e.alu_A;
  assign aluA_w[1]  = bus_f.alu_A;
  assign aluB_w[0]  = bus_e.alu_B;
  assign aluB_w[1]  = bus_f.alu_B;
  assign aluop_w[0] = bus_e.alu_op;
  assign aluop_w[1] = bus_f.alu_op;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic string sfx(input int d);
    return (d == 0) ? "_early" : "_full";
  endfunction

  task automatic do_mul(input logic [15:0] ma, input logic [15:0] mb, input bit repulse);
    int          n;
    int          k;
    int          iters;
    int          lat      [2];
    int          done_at  [2];
    int          done_cnt [2];
    int          pass_err [2];
    int          hold_err [2];
    int          seq_bad;
    logic [15:0] prod_at  [2];
    logic [15:0] prev_prod[2];
    logic [15:0] exp_p;
    logic [15:0] pi;
    logic [15:0] mi;
    logic [15:0] qi;
    logic [31:0] mask;
    logic [34:0] seq[$];
    logic [34:0] exp_e[$];
    logic [34:0] exp_f[$];
    logic [34:0] obs_e[$];
    logic [34:0] obs_f[$];
    logic [34:0] cur;

    n = 0;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (mb[i]) begin
        n = i + 1;
        k++;
      end
    end
    exp_p  = 16'(32'(ma) * 32'(mb));
    lat[0] = 1 + 3 * n + k;
    lat[1] = 49 + k;

    // Expected ALU traffic: iteration i sees P = a*(b mod 2^i), M = a<<i, Q = b>>i.
    for (int d = 0; d < 2; d++) begin
      seq.delete();
      iters = (d == 0) ? n : 16;
      for (int i = 0; i < iters; i++) begin
        mask = (32'd1 << i) - 32'd1;
        pi   = 16'(32'(ma) * (32'(mb) & mask));
        mi   = 16'(32'(ma) << i);
        qi   = mb >> i;
        seq.push_back({3'd0, 16'd0, 16'd0});
        if (mb[i]) seq.push_back({3'd2, pi, mi});
        seq.push_back({3'd4, mi, 16'h0001});
        seq.push_back({3'd4, qi, 16'hFFFF});
      end
      seq.push_back({3'd0, 16'd0, 16'd0});
      if (d == 0) exp_e = seq;
      else        exp_f = seq;
    end

    @(negedge clk);
    st   = 1'b1;
    op_a = ma;
    op_b = mb;
    for (int d = 0; d < 2; d++) begin
      prev_prod[d] = prod_w[d];
      done_at[d]   = -1;
      done_cnt[d]  = 0;
      pass_err[d]  = 0;
      hold_err[d]  = 0;
      prod_at[d]   = '0;
    end
    @(posedge clk);

    for (int c = 0; c <= lat[1] + 1; c++) begin
      #1;
      if (c == 0) begin
        chk("busy_rise_early", 32'(busy_w[0]), 32'd1);
        chk("busy_rise_full",  32'(busy_w[1]), 32'd1);
      end
      for (int d = 0; d < 2; d++) begin
        cur = {aluop_w[d], aluA_w[d], aluB_w[d]};
        if (busy_w[d]) begin
          if (d == 0) obs_e.push_back(cur);
          else        obs_f.push_back(cur);
        end else if (cur !== {x_op, x_A, x_B}) begin
          pass_err[d]++;
        end
        if (done_w[d]) begin
          done_cnt[d]++;
          if (busy_w[d]) pass_err[d]++;
          if (done_at[d] < 0) begin
            done_at[d] = c;
            prod_at[d] = prod_w[d];
          end
        end
        if (c < lat[d] && prod_w[d] !== prev_prod[d]) hold_err[d]++;
      end
      @(negedge clk);
      st   = repulse && (c >= 1) && (c <= 3);
      op_a = 16'($urandom);
      op_b = 16'($urandom);
      x_A  = 16'($urandom);
      x_B  = 16'($urandom);
      x_op = 3'($urandom_range(0, 5));
      @(posedge clk);
    end
    #1;

    for (int d = 0; d < 2; d++) begin
      chk({"done_edge", sfx(d)}, 32'(done_at[d]), 32'(lat[d]));
      chk({"done_count", sfx(d)}, 32'(done_cnt[d]), 32'd1);
      chk({"product", sfx(d)}, 32'(prod_at[d]), 32'(exp_p));
      chk({"product_held", sfx(d)}, 32'(prod_w[d]), 32'(exp_p));
      chk({"passthrough", sfx(d)}, 32'(pass_err[d]), 32'd0);
      chk({"product_stable", sfx(d)}, 32'(hold_err[d]), 32'd0);
    end

    chk("alu_seq_len_early", 32'(obs_e.size()), 32'(exp_e.size()));
    seq_bad = 0;
    for (int i = 0; i < obs_e.size() && i < exp_e.size(); i++)
      if (obs_e[i] !== exp_e[i]) seq_bad++;
    chk("alu_seq_early", 32'(seq_bad), 32'd0);

    chk("alu_seq_len_full", 32'(obs_f.size()), 32'(exp_f.size()));
    seq_bad = 0;
    for (int i = 0; i < obs_f.size() && i < exp_f.size(); i++)
      if (obs_f[i] !== exp_f[i]) seq_bad++;
    chk("alu_seq_full", 32'(seq_bad), 32'd0);
  endtask

  task automatic mid_reset();
    int dones;
    @(negedge clk);
    st   = 1'b1;
    op_a = 16'd7;
    op_b = 16'd9;
    @(posedge clk);
    @(negedge clk);
    st = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk({"rst_busy", sfx(d)}, 32'(busy_w[d]), 32'd0);
      chk({"rst_done", sfx(d)}, 32'(done_w[d]), 32'd0);
      chk({"rst_product", sfx(d)}, 32'(prod_w[d]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      if (done_w[0] || done_w[1] || busy_w[0] || busy_w[1]) dones++;
    end
    chk("aborted_no_done", 32'(dones), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;

    rst_n = 1'b0;
    x_op  = 3'd3;
    x_A   = 16'd10;
    x_B   = 16'd4;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk({"reset_busy", sfx(d)}, 32'(busy_w[d]), 32'd0);
      chk({"reset_done", sfx(d)}, 32'(done_w[d]), 32'd0);
      chk({"reset_product", sfx(d)}, 32'(prod_w[d]), 32'd0);
      chk({"reset_alu_op", sfx(d)}, 32'(aluop_w[d]), 32'd3);
      chk({"reset_alu_A", sfx(d)}, 32'(aluA_w[d]), 32'd10);
      chk({"reset_alu_B", sfx(d)}, 32'(aluB_w[d]), 32'd4);
    end
    @(negedge clk);
    rst_n = 1'b1;

    do_mul(16'd3, 16'd5, 1'b0);
    do_mul(16'h1234, 16'h0000, 1'b0);
    do_mul(16'h1234, 16'hFFFF, 1'b0);
    do_mul(16'hFFFF, 16'hFFFF, 1'b0);
    do_mul(16'd7, 16'd9, 1'b1);
    mid_reset();
    do_mul(16'd7, 16'd9, 1'b0);

    for (int t = 0; t < 16; t++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = 16'($urandom);
        1:       rb = 16'($urandom_range(0, 255));
        default: rb = 16'h0001 << $urandom_range(0, 15);
      endcase
      do_mul(ra, rb, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
